binary_tree_decoder: RTL

- Decoder-side mirror of the arithmetic encoder's `binary_tree` frequency model.
- Takes a scaled cumulative-count target computed by the arithmetic decoder core and searches an adaptive Fenwick (binary indexed) tree. It returns the symbol whose interval contains the target, plus that interval's lower bound, upper bound and total range.
- After each lookup it updates the model with the same rule the encoder uses, so both ends stay in lockstep symbol by symbol.

---
 rtl/binary_tree_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/binary_tree_decoder.sv
// Adaptive Fenwick-tree frequency model for the arithmetic decoder: maps a scaled
// cumulative target to a symbol and its interval, then applies the encoder's update rule.
module binary_tree_decoder #(
   parameter logic [15:0] INC       = 16'd32,
   parameter logic [15:0] MAX_TOTAL = 16'hFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] target_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic [7:0]  symbol_out,
   output logic [15:0] lower_bound_out,
   output logic [15:0] upper_bound_out,
   output logic [15:0] range_out,
   output logic        valid_out,
   output logic        err_out,
   output logic [15:0] total_out
);

   // state  | meaning
   // INIT   | rewrite tree/freq to uniform, one entry per cycle (256 cycles)
   // IDLE   | ready for a target
   // SEARCH | 8 descent steps over the tree, step 128 down to 1
   // RESULT | register the lookup result, bump freq/total
   // UPDATE | walk the Fenwick chain from sym+1 adding INC
   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_SEARCH,
      S_RESULT,
      S_UPDATE
   } state_t;

   state_t      state_q;
   logic [8:0]  idx_q;
   logic [15:0] target_q;
   logic [8:0]  pos_q;
   logic [15:0] rem_q;
   logic [7:0]  step_q;
   logic [15:0] tree_q [1:256];
   logic [15:0] freq_q [0:255];
   logic [15:0] total_q;
   logic        ready_q;
   logic        pend_q;
   logic        pend_err_q;
   logic        valid_q;
   logic        err_q;
   logic [7:0]  sym_q;
   logic [15:0] lo_q;
   logic [15:0] up_q;
   logic [15:0] rng_q;

   logic [8:0]  probe_idx;
   logic [15:0] probe_val;
   logic [8:0]  init_i;
   logic [8:0]  init_lsb;
   logic [9:0]  upd_nxt;
   logic        res_err;
   logic [15:0] res_lo;
   logic [15:0] res_up;

   always_comb begin
      probe_idx = pos_q + {1'b0, step_q};
      probe_val = tree_q[probe_idx];
      init_i    = idx_q + 9'd1;
      init_lsb  = init_i & (~init_i + 9'd1);
      upd_nxt   = {1'b0, idx_q} + {1'b0, idx_q & (~idx_q + 9'd1)};
      res_err   = (target_q >= total_q);
      res_lo    = target_q - rem_q;
      res_up    = res_lo + freq_q[pos_q[7:0]];
   end

   // The result registers load in RESULT; valid/err follow one cycle later so the
   // pulse lands 10 edges after the accepting edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_INIT;
         idx_q      <= 9'd0;
         ready_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_err_q <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         sym_q      <= 8'd0;
         lo_q       <= 16'd0;
         up_q       <= 16'd0;
         rng_q      <= 16'd0;
         total_q    <= 16'd256;
      end else begin
         valid_q    <= pend_q;
         err_q      <= pend_err_q;
         pend_q     <= 1'b0;
         pend_err_q <= 1'b0;
         case (state_q)
            S_INIT: begin
               tree_q[init_i]       <= {7'd0, init_lsb};
               freq_q[idx_q[7:0]]   <= 16'd1;
               total_q              <= 16'd256;
               idx_q                <= init_i;
               if (idx_q == 9'd255) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (valid_in) begin
                  target_q <= target_in;
                  pos_q    <= 9'd0;
                  rem_q    <= target_in;
                  step_q   <= 8'd128;
                  ready_q  <= 1'b0;
                  state_q  <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (probe_val <= rem_q) begin
                  pos_q <= probe_idx;
                  rem_q <= rem_q - probe_val;
               end
               step_q <= step_q >> 1;
               if (step_q == 8'd1) state_q <= S_RESULT;
            end
            S_RESULT: begin
               pend_q     <= 1'b1;
               pend_err_q <= res_err;
               rng_q      <= total_q;
               if (res_err) begin
                  sym_q   <= 8'd0;
                  lo_q    <= 16'd0;
                  up_q    <= 16'd0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  sym_q                <= pos_q[7:0];
                  lo_q                 <= res_lo;
                  up_q                 <= res_up;
                  freq_q[pos_q[7:0]]   <= freq_q[pos_q[7:0]] + INC;
                  total_q              <= total_q + INC;
                  idx_q                <= pos_q + 9'd1;
                  state_q              <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               tree_q[idx_q] <= tree_q[idx_q] + INC;
               idx_q         <= upd_nxt[8:0];
               if (upd_nxt > 10'd256) begin
                  if (total_q >= MAX_TOTAL) begin
                     idx_q   <= 9'd0;
                     state_q <= S_INIT;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               idx_q   <= 9'd0;
               state_q <= S_INIT;
            end
         endcase
      end
   end

   assign ready_out       = ready_q;
   assign valid_out       = valid_q;
   assign err_out         = err_q;
   assign symbol_out      = sym_q;
   assign lower_bound_out = lo_q;
   assign upper_bound_out = up_q;
   assign range_out       = rng_q;
   assign total_out       = total_q;

endmodule
